alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Clocked command sequencer in front of the ALU function units (suma, complemento, shiftl,
//  shiftR, compc, compn, load). Accepts one opcode+operand command at a time and issues a
//  one-cycle start to the selected unit. Waits for that unit's done, then returns its result
//  on a valid/ready response port. Replaces combinational opcode steering with a handshaked FSM.
// PARAMETERS
//  DATA_W          8    operand/result width
//  TIMEOUT_CYCLES  255  WAIT cycles before abort (used only with ALU_SEQ_TIMEOUT_EN)
//  CNT_W           8    watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         reset, asynchronous, active-low
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         sequencer can accept command
//  cmd_opcode   in   3         0 suma,1 complemento,2 shiftl,3 shiftR,4 compc,5 compn,7 load; 6 illegal
//  cmd_data     in   DATA_W    operand
//  unit_start   out  7         one-hot start; bit i = unit i (opcode 7 -> bit 6)
//  unit_data    out  DATA_W    operand to units, registered
//  unit_done    in   7         per-unit done, same indexing as unit_start
//  unit_result  in   7*DATA_W  per-unit result; unit i at [i*DATA_W +: DATA_W]
//  rsp_valid    out  1         response present
//  rsp_ready    in   1         consumer accepts response
//  rsp_data     out  DATA_W    captured result (0 on error)
//  rsp_err      out  2         00 ok, 01 illegal opcode, 10 timeout
//  busy         out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. unit_start=0, unit_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
//  All outputs registered except cmd_ready (=state==IDLE) and busy (=state!=IDLE).
//  IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready; latch opcode, operand into unit_data.
//    opcode 6 -> RESP with rsp_err=01, rsp_data=0; no unit_start.
//    Otherwise -> DISPATCH.
//  DISPATCH: unit_start[sel]=1 for exactly one cycle -> WAIT.
//  WAIT: sample unit_done[sel] only; done bits of other units ignored.
//    On done: capture unit_result[sel] into rsp_data, rsp_err=00 -> RESP.
//    unit_done[sel] during DISPATCH is ignored; units must assert done >=1 cycle after start.
//  RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_valid&rsp_ready -> IDLE.
//    rsp_valid drops the cycle after the handshake.
//    cmd_ready=0, so a new command is not accepted in the same cycle.
//  Latency: cmd accept edge T -> unit_start high cycle T+1. Unit done at cycle D ->
//    rsp_valid high from D+1. Legal command minimum: 4 cycles/command with done 1 cycle
//    after start and rsp_ready held high.
//  unit_data holds the operand from accept through RESP; it changes only on the next accept.
//  rst_n low at any point aborts asynchronously: unit_start drops immediately, the command
//    is lost, and no response is issued.
// CONFIGURATION
//  ALU_SEQ_TIMEOUT_EN defined:
//    Watchdog counter clears on WAIT entry and increments each WAIT cycle.
//    If it reaches TIMEOUT_CYCLES without done: rsp_data=0, rsp_err=10 -> RESP.
//    If done and timeout occur in the same cycle, done wins (err=00).
//    A late done after a timeout is ignored.
//  ALU_SEQ_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; rsp_err[1] is always 0.
// TESTING
//  1. opcode=0, data=8'h05; unit0 done 3 cycles after start, result 8'h0A ->
//     unit_start=7'b0000001 for 1 cycle, rsp_data=8'h0A, rsp_err=00.
//  2. opcode=7, data=8'h3C ->
//     unit_start=7'b1000000, unit_data=8'h3C held through RESP, rsp_data=unit6 result.
//  3. opcode=6 -> no unit_start; rsp_valid next cycle, rsp_err=01, rsp_data=8'h00.
//  4. rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0;
//     a cmd_valid presented then is accepted only after the handshake.
//  5. opcode=3 while unit_done[0] pulses -> ignored; completes only on unit_done[3].
//     rst_n low mid-WAIT -> all outputs 0, no response.
//  6. ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, unit never done -> rsp_err=10 after 4 WAIT cycles.
//     Done on the timeout cycle -> rsp_err=00.

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Handshaked command sequencer in front of the ALU function units
//            (suma, complemento, shiftl, shiftR, compc, compn, load). Takes
//            one opcode+operand command at a time, pulses a one-cycle start to
//            the selected unit, waits for that unit's done and returns the
//            captured result on a valid/ready response port.
// Ports    : clk, rst_n            - rising-edge clock, async active-low reset
//            cmd_valid/cmd_ready   - command handshake
//            cmd_opcode, cmd_data  - 3-bit opcode (6 illegal), operand
//            unit_start[6:0]       - registered one-hot start (opcode 7 -> bit 6)
//            unit_data             - registered operand, held until next accept
//            unit_done[6:0]        - per-unit done, same indexing as start
//            unit_result           - unit i result at [i*DATA_W +: DATA_W]
//            rsp_valid/rsp_ready   - response handshake
//            rsp_data, rsp_err     - result (0 on error); 00 ok/01 illegal/10 timeout
//            busy                  - high whenever the FSM is not idle
// Config   : `define ALU_SEQ_TIMEOUT_EN to enable the WAIT watchdog
//            (TIMEOUT_CYCLES, CNT_W). Without it WAIT holds indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [DATA_W-1:0]     cmd_data,
  output logic [6:0]            unit_start,
  output logic [DATA_W-1:0]     unit_data,
  input  logic [6:0]            unit_done,
  input  logic [7*DATA_W-1:0]   unit_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  busy
);

  localparam int          c_NUM_UNITS = 7;
  localparam logic [6:0]  c_START_ONE = 7'd1;
  localparam logic [2:0]  c_OP_ILLEGAL = 3'd6;
  localparam logic [2:0]  c_OP_LOAD    = 3'd7;
  localparam logic [1:0]  c_ERR_OK      = 2'b00;
  localparam logic [1:0]  c_ERR_ILLEGAL = 2'b01;
`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [1:0]  c_ERR_TIMEOUT = 2'b10;
  // Counter value seen on the last permitted WAIT cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Elaboration guard: the watchdog counter must be able to hold the limit.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_timeout_cfg
    $error("alu_sequencer: TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_sel;
  logic [2:0]          w_sel_next;
  logic [6:0]          w_start_next;
  logic [DATA_W-1:0]   w_udata_next;
  logic                w_valid_next;
  logic [DATA_W-1:0]   w_rdata_next;
  logic [1:0]          w_err_next;

  logic [2:0]          w_cmd_sel;
  logic                w_cmd_illegal;
  logic                w_done_sel;
  logic [DATA_W-1:0]   w_result_sel;
  logic [DATA_W-1:0]   w_result_arr [c_NUM_UNITS];

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
`endif

  // Split the flat result bus into one lane per unit.
  for (genvar gi = 0; gi < c_NUM_UNITS; gi++) begin : g_unpack_result
    assign w_result_arr[gi] = unit_result[gi*DATA_W +: DATA_W];
  end

  // Opcode 7 (load) lives on unit lane 6; opcode 6 has no unit.
  assign w_cmd_illegal = (cmd_opcode == c_OP_ILLEGAL);
  assign w_cmd_sel     = (cmd_opcode == c_OP_LOAD) ? 3'd6 : cmd_opcode;

  // Only the selected unit's done/result are observed.
  assign w_done_sel   = unit_done[r_sel];
  assign w_result_sel = w_result_arr[r_sel];

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_start_next = '0;
    w_udata_next = unit_data;
    w_valid_next = rsp_valid;
    w_rdata_next = rsp_data;
    w_err_next   = rsp_err;
`ifdef ALU_SEQ_TIMEOUT_EN
    w_cnt_next   = r_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_udata_next = cmd_data;
          w_sel_next   = w_cmd_sel;
          if (w_cmd_illegal) begin
            w_state_next = ST_RESP;
            w_valid_next = 1'b1;
            w_rdata_next = '0;
            w_err_next   = c_ERR_ILLEGAL;
          end else begin
            // Start is registered so it is high exactly during DISPATCH.
            w_state_next = ST_DISPATCH;
            w_start_next = c_START_ONE << w_cmd_sel;
          end
        end
      end

      ST_DISPATCH: begin
        // Done seen here is ignored; units answer at least one cycle later.
        w_state_next = ST_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
        w_cnt_next   = '0;
`endif
      end

      ST_WAIT: begin
        if (w_done_sel) begin
          // Done has priority over a coincident timeout.
          w_state_next = ST_RESP;
          w_valid_next = 1'b1;
          w_rdata_next = w_result_sel;
          w_err_next   = c_ERR_OK;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state_next = ST_RESP;
          w_valid_next = 1'b1;
          w_rdata_next = '0;
          w_err_next   = c_ERR_TIMEOUT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        // Late done from a timed-out unit lands here and is ignored.
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
          w_valid_next = 1'b0;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      unit_start <= '0;
      unit_data  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sel      <= w_sel_next;
      unit_start <= w_start_next;
      unit_data  <= w_udata_next;
      rsp_valid  <= w_valid_next;
      rsp_data   <= w_rdata_next;
      rsp_err    <= w_err_next;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Directed vector table for
//            one command per opcode, plus hand-written sequences for
//            back-pressure, foreign done pulses, reset aborts and (when
//            ALU_SEQ_TIMEOUT_EN is defined) the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_opcode = '0;
  logic [DW-1:0]   cmd_data = '0;
  logic [6:0]      unit_start;
  logic [DW-1:0]   unit_data;
  logic [6:0]      unit_done = '0;
  logic [7*DW-1:0] unit_result;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_err;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_data    (cmd_data),
    .unit_start  (unit_start),
    .unit_data   (unit_data),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural unit results, derived from the operand the sequencer drives.
  always_comb begin
    unit_result = '0;
    unit_result[0*DW +: DW] = unit_data + unit_data;   // suma (operand doubled)
    unit_result[1*DW +: DW] = ~unit_data;              // complemento
    unit_result[2*DW +: DW] = unit_data << 1;          // shiftl
    unit_result[3*DW +: DW] = unit_data >> 1;          // shiftR
    unit_result[4*DW +: DW] = ~unit_data + 8'd1;       // compc
    unit_result[5*DW +: DW] = unit_data ^ 8'h55;       // compn
    unit_result[6*DW +: DW] = unit_data;               // load
  end

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] data;
    int            delay;   // cycles from start to done (>= 1)
    logic [6:0]    start;
    logic [DW-1:0] res;
    logic [1:0]    err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [DW-1:0] d);
    int budget;
    budget = 20;
    while (!cmd_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_data   = d;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    send(v.op, v.data);
    if (v.op != 3'd6) begin
      check("start_onehot", {25'd0, unit_start}, {25'd0, v.start});
      check("unit_data_dispatch", {24'd0, unit_data}, {24'd0, v.data});
      check("busy_dispatch", {31'd0, busy}, 32'd1);
      tick();
      check("start_one_cycle", {25'd0, unit_start}, 32'd0);
      for (int k = 1; k < v.delay; k++) begin
        check("no_early_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
      end
      unit_done = v.start;
      tick();
      unit_done = '0;
    end else begin
      check("illegal_no_start", {25'd0, unit_start}, 32'd0);
    end
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_data", {24'd0, rsp_data}, {24'd0, v.res});
    check("rsp_err", {30'd0, rsp_err}, {30'd0, v.err});
    check("unit_data_resp", {24'd0, unit_data}, {24'd0, v.data});
    check("cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
    handshake();
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'h05, 3, 7'h01, 8'h0A, 2'b00};
    vecs[1] = '{3'd1, 8'h0F, 1, 7'h02, 8'hF0, 2'b00};
    vecs[2] = '{3'd2, 8'h81, 2, 7'h04, 8'h02, 2'b00};
    vecs[3] = '{3'd3, 8'h81, 1, 7'h08, 8'h40, 2'b00};
    vecs[4] = '{3'd4, 8'h01, 2, 7'h10, 8'hFF, 2'b00};
    vecs[5] = '{3'd5, 8'h3C, 1, 7'h20, 8'h69, 2'b00};
    vecs[6] = '{3'd7, 8'h3C, 4, 7'h40, 8'h3C, 2'b00};
    vecs[7] = '{3'd6, 8'hAA, 1, 7'h00, 8'h00, 2'b01};

    // Reset state
    tick();
    tick();
    check("rst_unit_start", {25'd0, unit_start}, 32'd0);
    check("rst_unit_data", {24'd0, unit_data}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Table-driven single commands
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Back-pressure: response held 5 cycles while a new command waits
    send(3'd1, 8'h0F);
    tick();
    unit_done = 7'h02;
    tick();
    unit_done = '0;
    cmd_valid  = 1'b1;
    cmd_opcode = 3'd0;
    cmd_data   = 8'h05;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", {24'd0, rsp_data}, 32'hF0);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_no_start", {25'd0, unit_start}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_after_hs_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_not_same_cycle", {25'd0, unit_start}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_accept_start", {25'd0, unit_start}, 32'h01);
    check("bp_accept_data", {24'd0, unit_data}, 32'h05);
    tick();
    unit_done = 7'h01;
    tick();
    unit_done = '0;
    check("bp_second_rsp", {24'd0, rsp_data}, 32'h0A);
    handshake();

    // Foreign done pulses are ignored; only unit 3 completes opcode 3
    send(3'd3, 8'h81);
    unit_done = 7'h01;
    tick();
    tick();
    tick();
    check("foreign_done_ignored", {31'd0, rsp_valid}, 32'd0);
    check("foreign_busy", {31'd0, busy}, 32'd1);
    unit_done = 7'h08;
    tick();
    unit_done = '0;
    check("sel_done_valid", {31'd0, rsp_valid}, 32'd1);
    check("sel_done_data", {24'd0, rsp_data}, 32'h40);
    handshake();

    // Reset during DISPATCH drops the start pulse at once
    send(3'd2, 8'h11);
    rst_n = 1'b0;
    #1;
    check("rst_dispatch_start", {25'd0, unit_start}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-WAIT aborts with no response
    send(3'd0, 8'h05);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_wait_start", {25'd0, unit_start}, 32'd0);
    check("rst_wait_data", {24'd0, unit_data}, 32'd0);
    check("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wait_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    unit_done = 7'h01;
    tick();
    unit_done = '0;
    tick();
    check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_idle", {31'd0, cmd_ready}, 32'd1);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Unit never answers: timeout after 4 WAIT cycles
    send(3'd0, 8'h05);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("to_no_early", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check("to_last_wait", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("to_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_err", {30'd0, rsp_err}, 32'd2);
    check("to_data", {24'd0, rsp_data}, 32'd0);
    unit_done = 7'h01;
    tick();
    unit_done = '0;
    check("to_late_done_err", {30'd0, rsp_err}, 32'd2);
    handshake();

    // Done on the timeout cycle wins
    send(3'd0, 8'h05);
    tick();
    tick();
    tick();
    tick();
    unit_done = 7'h01;
    tick();
    unit_done = '0;
    check("to_tie_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_tie_err", {30'd0, rsp_err}, 32'd0);
    check("to_tie_data", {24'd0, rsp_data}, 32'h0A);
    handshake();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
